// File: rtl/screenchar_pkg.sv
// Shared definitions for the screen-character field scheduler.
package screenchar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CONVERT,
    ST_WRITE,
    ST_TERM_START,
    ST_TERM_WAIT,
    ST_DONE
  } state_t;

  localparam logic [7:0] CHAR_BLANK = 8'h20;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_OVF   = 8'h23;

  // ASCII code of a single BCD digit
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CHAR_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, VAL_W cycles per conversion.
// Overflow is flagged when a set bit would be shifted out of the top BCD digit.
module bin_to_bcd_seq #(
  parameter int VAL_W  = 32,
  parameter int DIGITS = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [VAL_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]    shift_q, shift_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d;
  logic [DIGITS*4-1:0] adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  // Load on start, otherwise add-3 adjust and shift one bit per busy cycle
  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    adj     = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end
    end
    if (start) begin
      shift_d = value;
      bcd_d   = '0;
      cnt_d   = CNT_W'(VAL_W);
      busy_d  = 1'b1;
      ovf_d   = 1'b0;
    end else if (busy_q) begin
      ovf_d   = ovf_q | adj[DIGITS*4-1];
      bcd_d   = {adj[DIGITS*4-2:0], shift_q[VAL_W-1]};
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Converter state registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // done marks the cycle whose closing edge completes the final shift
  assign done     = busy_q && (cnt_q == CNT_W'(1));
  assign busy     = busy_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/screenchar_field_scheduler.sv
// Round-robins numeric fields and a terminal text stream into the screen RAM write port.
module screenchar_field_scheduler
  import screenchar_pkg::*;
#(
  parameter int NUM_FIELDS  = 4,
  parameter int VAL_W       = 32,
  parameter int DIGITS      = 6,
  parameter int ADDR_W      = 8,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_FIELDS*VAL_W-1:0]  field_values,
  input  logic [NUM_FIELDS*ADDR_W-1:0] field_lsd_addr,
  input  logic [NUM_FIELDS-1:0]      field_en,
  input  logic                       force_refresh,
  output logic                       term_start,
  input  logic                       term_valid,
  input  logic [ADDR_W-1:0]          term_index,
  input  logic [7:0]                 term_data,
  input  logic                       term_finish,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       frame_done
);

  localparam int PTR_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_FIELDS - 1);
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(DIGITS - 1);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic [NUM_FIELDS-1:0] dirty_q, dirty_d;
  logic [VAL_W-1:0]    shadow_q [NUM_FIELDS];
  logic [VAL_W-1:0]    shadow_d [NUM_FIELDS];
  logic [ADDR_W-1:0]   lsd_q, lsd_d;
  logic                first_wait_q, first_wait_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;

  logic [VAL_W-1:0]    cur_value;
  logic [ADDR_W-1:0]   cur_addr;
  logic                take;
  logic                conv_start, conv_busy, conv_done, conv_ovf;
  logic [DIGITS*4-1:0] conv_bcd;
  logic [3:0]          digit_cur;
  logic                upper_zero;
  logic [7:0]          char_sel;

  bin_to_bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clock    (clock),
    .resetn   (resetn),
    .start    (conv_start),
    .value    (cur_value),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  assign cur_value = field_values[int'(ptr_q)*VAL_W +: VAL_W];
  assign cur_addr  = field_lsd_addr[int'(ptr_q)*ADDR_W +: ADDR_W];

  // A field is rewritten only when enabled and dirty, forced, or changed since last written
  always_comb begin
    take = field_en[ptr_q] &&
           (dirty_q[ptr_q] || force_refresh || (cur_value != shadow_q[ptr_q]));
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for one full pass over fields then the terminal region
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       state_d = ST_SELECT;
      ST_SELECT: begin
        if (take) begin
          state_d = ST_CONVERT;
        end else if (ptr_q == LAST_PTR) begin
          state_d = ST_TERM_START;
        end
      end
      ST_CONVERT:    if (conv_done) state_d = ST_WRITE;
      ST_WRITE: begin
        if (dig_q == LAST_DIG) begin
          state_d = (ptr_q == LAST_PTR) ? ST_TERM_START : ST_SELECT;
        end
      end
      ST_TERM_START: state_d = ST_TERM_WAIT;
      ST_TERM_WAIT:  if (!first_wait_q && term_finish) state_d = ST_DONE;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Character for the digit being written: overflow mark, blanked leading zero, or ASCII digit
  always_comb begin
    digit_cur  = conv_bcd[int'(dig_q)*4 +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j > int'(dig_q)) && (conv_bcd[j*4 +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    if (conv_ovf) begin
      char_sel = CHAR_OVF;
    end else if ((BLANK_ZEROS != 0) && (dig_q != '0) && (digit_cur == 4'd0) && upper_zero) begin
      char_sel = CHAR_BLANK;
    end else begin
      char_sel = digit_char(digit_cur);
    end
  end

  // Outputs: state-decoded pulses plus the next value of the registered write port
  always_comb begin
    term_start = (state_q == ST_TERM_START);
    frame_done = (state_q == ST_DONE);
    conv_start = (state_q == ST_SELECT) && take && !conv_busy;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    case (state_q)
      ST_WRITE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = lsd_q - ADDR_W'(dig_q);
        wr_data_d = char_sel;
      end
      ST_TERM_WAIT: begin
        if (term_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = term_index;
          wr_data_d = term_data;
        end
      end
      default: ;
    endcase
  end

  // Field pointer, digit counter, shadow values and dirty flags
  always_comb begin
    ptr_d        = ptr_q;
    dig_d        = dig_q;
    dirty_d      = dirty_q;
    shadow_d     = shadow_q;
    lsd_d        = lsd_q;
    first_wait_d = first_wait_q;
    case (state_q)
      ST_IDLE: ptr_d = '0;
      ST_SELECT: begin
        if (take) begin
          shadow_d[ptr_q] = cur_value;
          dirty_d[ptr_q]  = 1'b0;
          lsd_d           = cur_addr;
          dig_d           = '0;
        end else if (ptr_q != LAST_PTR) begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      ST_WRITE: begin
        if (dig_q == LAST_DIG) begin
          dig_d = '0;
          if (ptr_q != LAST_PTR) begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end else begin
          dig_d = dig_q + DIG_W'(1);
        end
      end
      ST_TERM_START: first_wait_d = 1'b1;
      ST_TERM_WAIT:  first_wait_d = 1'b0;
      default: ;
    endcase
    dirty_d = dirty_d | ~field_en;
  end

  // Datapath and write-port registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ptr_q        <= '0;
      dig_q        <= '0;
      dirty_q      <= '1;
      lsd_q        <= '0;
      first_wait_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      dig_q        <= dig_d;
      dirty_q      <= dirty_d;
      lsd_q        <= lsd_d;
      first_wait_q <= first_wait_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      shadow_q     <= shadow_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
